// File: rtl/sd_rdata_checker.sv
// sd_rdata_checker: checks an SD read block against the 0..255 byte ramp and keeps a readback copy.
module sd_rdata_checker #(
  parameter logic [23:0] TIMEOUT = 24'd5000000,
  parameter logic [9:0]  BLK_LEN = 10'd512
) (
  input  logic       SD_clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  input  logic       rdone_i,
  input  logic [8:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [9:0] err_cnt,
  output logic [8:0] first_err,
  output logic [9:0] byte_cnt,
  output logic [2:0] flags
);
  typedef enum logic [1:0] {IDLE, ARMED, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d, err_cnt_q, err_cnt_d;
  logic [8:0]  first_err_q, first_err_d;
  logic [2:0]  flags_q, flags_d;
  logic        pass_q, pass_d, acc, mis;
  logic [23:0] tmo_q, tmo_d;
  logic [7:0]  mem [512];
  logic [7:0]  rd_data_q;
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    flags_d     = flags_q;
    pass_d      = pass_q;
    tmo_d       = tmo_q;
    acc         = 1'b0;
    mis         = 1'b0;
    case (state_q)
      IDLE, DONE: if (start) begin
        state_d     = ARMED;
        byte_cnt_d  = '0;
        err_cnt_d   = '0;
        first_err_d = '0;
        flags_d     = '0;
        pass_d      = 1'b0;
        tmo_d       = '0;
      end
      ARMED: begin
        acc   = valid_i;
        mis   = valid_i && data_i != byte_cnt_q[7:0];
        tmo_d = valid_i ? '0 : tmo_q + 24'd1;
        if (acc && byte_cnt_q < BLK_LEN) byte_cnt_d = byte_cnt_q + 10'd1;
        if (mis && err_cnt_q != 10'd1023) err_cnt_d = err_cnt_q + 10'd1;
        // err_cnt_q is still zero only on the first mismatch, since it saturates instead of wrapping
        if (mis && err_cnt_q == '0) first_err_d = byte_cnt_q[8:0];
        if (rdone_i) begin
          state_d    = DONE;
          flags_d[1] = byte_cnt_d != BLK_LEN;
        end else if (acc && byte_cnt_q == BLK_LEN - 10'd1) state_d = FLUSH;
        else if (tmo_d == TIMEOUT) begin
          state_d    = DONE;
          flags_d[2] = 1'b1;
        end
      end
      FLUSH: begin
        tmo_d = valid_i ? '0 : tmo_q + 24'd1;
        if (valid_i) flags_d[0] = 1'b1;
        if (rdone_i) state_d = DONE;
        else if (tmo_d == TIMEOUT) begin
          state_d    = DONE;
          flags_d[2] = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (state_q != DONE && state_d == DONE) pass_d = err_cnt_d == '0 && byte_cnt_d == BLK_LEN && flags_d == '0;
  end
  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      byte_cnt_q  <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      flags_q     <= '0;
      pass_q      <= 1'b0;
      tmo_q       <= '0;
      rd_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      flags_q     <= flags_d;
      pass_q      <= pass_d;
      tmo_q       <= tmo_d;
      rd_data_q   <= mem[rd_addr];
    end
  end
  always_ff @(posedge SD_clk) begin
    if (acc) mem[byte_cnt_q[8:0]] <= data_i;
  end
  assign rd_data   = rd_data_q;
  assign busy      = state_q == ARMED || state_q == FLUSH;
  assign done      = state_q == DONE;
  assign pass      = pass_q;
  assign err_cnt   = err_cnt_q;
  assign first_err = first_err_q;
  assign byte_cnt  = byte_cnt_q;
  assign flags     = flags_q;
endmodule

// File: tb/tb_sd_rdata_checker.sv
// tb_sd_rdata_checker: random block streams scored against a per-block result model and a buffer shadow.
module tb_sd_rdata_checker;
  logic       SD_clk = 0, rst_n = 0, start = 0, valid_i = 0, rdone_i = 0;
  logic [7:0] data_i = 0;
  logic [8:0] rd_addr = 0;
  logic [7:0] rd_data;
  logic       busy, done, pass;
  logic [9:0] err_cnt, byte_cnt;
  logic [8:0] first_err;
  logic [2:0] flags;

  sd_rdata_checker #(.TIMEOUT(24'd100)) dut (
    .SD_clk(SD_clk), .rst_n(rst_n), .start(start), .data_i(data_i), .valid_i(valid_i),
    .rdone_i(rdone_i), .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err(first_err), .byte_cnt(byte_cnt), .flags(flags)
  );

  always #5 SD_clk = ~SD_clk;

  typedef struct packed {
    logic [9:0] err;
    logic [8:0] fe;
    logic [9:0] bc;
    logic [2:0] fl;
    logic       ps;
  } res_t;

  res_t       exp_q[$];
  res_t       got;
  int         vecs = 0, fails = 0;
  logic [7:0] blk[$];
  logic [7:0] mem_m[512];
  bit         known[512];
  logic       done_p = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge SD_clk);
    #1;
  endtask

  // Result monitor: each done rising edge consumes one expected block result.
  always @(negedge SD_clk) begin
    if (done && !done_p) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        got = exp_q.pop_front();
        chk("err_cnt", 32'(err_cnt), 32'(got.err));
        chk("first_err", 32'(first_err), 32'(got.fe));
        chk("byte_cnt", 32'(byte_cnt), 32'(got.bc));
        chk("flags", 32'(flags), 32'(got.fl));
        chk("pass", 32'(pass), 32'(got.ps));
        chk("busy_in_done", 32'(busy), 0);
      end
    end
    done_p = done;
  end

  task automatic mk(input int n);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(i < 512 ? 8'(i) : 8'hAA);
  endtask

  task automatic send(input bit rd);
    int   n = blk.size();
    int   bc = n < 512 ? n : 512;
    int   k = 0;
    bit   quick = 0;
    res_t e;
    e.err = 0;
    e.fe  = 0;
    for (int i = 0; i < bc; i++)
      if (blk[i] != 8'(i % 256)) begin
        if (e.err == 0) e.fe = 9'(i);
        e.err++;
      end
    e.bc = 10'(bc);
    e.fl = {!rd, rd && n < 512, n > 512};
    e.ps = e.err == 0 && bc == 512 && e.fl == 0;
    exp_q.push_back(e);
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick;
      valid_i = 1;
      data_i  = blk[i];
      if (i < 512) rd_addr = 9'(i);
      start   = i == 50;
      quick   = rd && n < 512 && i == n - 1 && $urandom_range(0, 1) == 1;
      rdone_i = quick;
      tick;
      valid_i = 0;
      start   = 0;
      rdone_i = 0;
      if (i < 512) begin
        if (known[i]) chk("rd_old_on_write", 32'(rd_data), 32'(mem_m[i]));
        mem_m[i] = blk[i];
        known[i] = 1;
      end
    end
    if (rd && !quick) begin
      repeat ($urandom_range(0, 3)) tick;
      rdone_i = 1;
      tick;
      rdone_i = 0;
    end
    while (!done && k < 300) begin
      tick;
      k++;
    end
    if (!done) chk("done_wait", 0, 1);
    tick;
  endtask

  task automatic check_idle_zero(input string nm);
    chk({nm, "_busy"}, 32'(busy), 0);
    chk({nm, "_done"}, 32'(done), 0);
    chk({nm, "_pass"}, 32'(pass), 0);
    chk({nm, "_err_cnt"}, 32'(err_cnt), 0);
    chk({nm, "_first_err"}, 32'(first_err), 0);
    chk({nm, "_byte_cnt"}, 32'(byte_cnt), 0);
    chk({nm, "_flags"}, 32'(flags), 0);
    chk({nm, "_rd_data"}, 32'(rd_data), 0);
  endtask

  initial begin
    repeat (3) tick;
    check_idle_zero("reset");
    rst_n = 1;
    tick;
    mk(512);
    send(1);
    mk(512);
    blk[100] = 8'hFF;
    blk[300] = 8'h00;
    send(1);
    mk(200);
    send(1);
    mk(10);
    send(0);
    mk(514);
    send(1);
    rd_addr = 0;
    tick;
    chk("buf0_after_overrun", 32'(rd_data), 0);
    rd_addr = 9'd257;
    tick;
    chk("buf257", 32'(rd_data), 1);
    start = 1;
    tick;
    start = 0;
    for (int i = 0; i < 100; i++) begin
      valid_i = 1;
      data_i  = 8'(i);
      tick;
      mem_m[i] = 8'(i);
      known[i] = 1;
    end
    valid_i = 0;
    chk("busy_before_reset", 32'(busy), 1);
    #2 rst_n = 0;
    #1 check_idle_zero("mid_reset");
    tick;
    rst_n = 1;
    repeat (5) tick;
    chk("idle_after_reset_busy", 32'(busy), 0);
    chk("idle_after_reset_done", 32'(done), 0);
    mk(512);
    send(1);
    repeat (6) begin
      mk($urandom_range(1, 515));
      repeat ($urandom_range(0, 3)) blk[$urandom_range(0, blk.size() - 1)] = 8'($urandom);
      send($urandom_range(0, 3) != 0);
    end
    repeat (16) begin
      rd_addr = 9'($urandom_range(0, 511));
      tick;
      if (known[rd_addr]) chk("readback", 32'(rd_data), 32'(mem_m[rd_addr]));
    end
    repeat (2) tick;
    if (exp_q.size() != 0) chk("pending_results", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule

// File: doc/sd_rdata_checker.md
SD_RDATA_CHECKER -- requirements
Module: sd_rdata_checker

Interface
REQ-001 Parameter TIMEOUT, default 24'd5000000, max SD_clk cycles allowed between accepted bytes (200 ms at 25 MHz).
REQ-002 Parameter BLK_LEN, default 10'd512, bytes per block.
REQ-003 SD_clk  input  1  SD SPI clock, 25 MHz; all logic on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse; arms a new block check; issued together with the sd_read read_req.
REQ-006 data_i  input  8  read byte from sd_read mydata_o.
REQ-007 valid_i  input  1  byte strobe from sd_read myvalid_o; one cycle per byte.
REQ-008 rdone_i  input  1  block-read-complete flag from sd_read read_o.
REQ-009 rd_addr  input  9  buffer readback address.
REQ-010 rd_data  output  8  buffer byte at rd_addr, registered.
REQ-011 busy  output  1  high in ARMED or FLUSH.
REQ-012 done  output  1  high in DONE; results valid.
REQ-013 pass  output  1  block matched pattern with no fault flags.
REQ-014 err_cnt  output  10  mismatching byte count, saturating at 1023.
REQ-015 first_err  output  9  index of first mismatching byte; 0 if none.
REQ-016 byte_cnt  output  10  bytes accepted this block, saturating at BLK_LEN.
REQ-017 flags  output  3  {timeout, short, overrun}.

Function
REQ-018 FSM states: IDLE, ARMED, FLUSH, DONE; encoded in 2 bits.
REQ-019 IDLE or DONE + start -> ARMED; clears byte_cnt, err_cnt, first_err, flags, pass, timeout counter.
REQ-020 start while busy is ignored.
REQ-021 In ARMED, each valid_i cycle writes data_i to buffer[byte_cnt[8:0]] and increments byte_cnt.
REQ-022 Expected byte = byte_cnt[7:0] at acceptance (pattern 0..255,0..255); mismatch increments err_cnt.
REQ-023 On the first mismatch, byte_cnt[8:0] is latched into first_err; later mismatches leave it unchanged.
REQ-024 When the accepted byte is byte BLK_LEN-1, next state FLUSH.
REQ-025 FLUSH: further valid_i sets overrun, not stored, not compared; rdone_i -> DONE.
REQ-026 ARMED + rdone_i before BLK_LEN bytes -> DONE, short set; a byte arriving in the same cycle is still accepted and compared.
REQ-027 Timeout counter runs in ARMED and FLUSH, clears on each valid_i; reaching TIMEOUT -> DONE, timeout set.
REQ-028 pass is registered on DONE entry: 1 iff err_cnt==0 and byte_cnt==BLK_LEN and flags==0.
REQ-029 DONE holds all results until the next start; valid_i and rdone_i are ignored in IDLE and DONE.
REQ-030 Buffer is a 512x8 synchronous RAM, one write port and one read port; rd_data = buffer[rd_addr] one cycle after rd_addr is presented.
REQ-031 Reading an address in the same cycle it is written returns the old content.

Reset
REQ-032 rst_n low asynchronously forces IDLE; busy, done, pass, err_cnt, first_err, byte_cnt, flags and the timeout counter go to 0.
REQ-033 rd_data resets to 8'h00; buffer contents are not reset.
REQ-034 Reset mid-block aborts the check; after release the block stays in IDLE until start.

Verification
REQ-035 start, then 512 bytes 0..255,0..255 with gaps of 0-3 cycles, then rdone_i -> done=1, pass=1, err_cnt=0, byte_cnt=512, flags=000.
REQ-036 As REQ-035 with byte 100 = 8'hFF and byte 300 = 8'h00 -> err_cnt=2, first_err=100, pass=0.
REQ-037 start, 200 correct bytes, then rdone_i -> done=1, short=1, byte_cnt=200, pass=0.
REQ-038 start, 10 bytes, then silence for TIMEOUT cycles (TIMEOUT overridden to 100) -> done=1, timeout=1, byte_cnt=10, busy=0.
REQ-039 512 correct bytes, 2 extra valid_i, then rdone_i -> overrun=1, pass=0, buffer[0] still 8'h00; then rd_addr=257 -> rd_data=8'h01 one cycle later.
REQ-040 Assert rst_n low mid-block, release, then run a second start with full correct stream -> all outputs 0 after reset; second run passes.
